// File: rtl/cpu_defines.sv
// rtl/cpu_defines.sv - shared CPU types, constants and fetch FSM encoding
package cpu_defines;

    typedef logic [31:0] Inst_addr_t;
    typedef logic [31:0] Inst_t;
    typedef logic        Bit_t;
    typedef logic [5:0]  Stall_t;

    localparam Bit_t  ENABLE   = 1'b1;
    localparam Bit_t  DISABLE  = 1'b0;
    localparam Inst_t NOP_INST = 32'h0000_0000;

    // Index into Stall_t: bit0 holds the PC, bit1 holds the IF/ID boundary.
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    // Bundle handed to decode; also the layout of the 66-bit hold buffer.
    typedef struct packed {
        Inst_addr_t pc;
        Inst_t      inst;
        Bit_t       valid;
        Bit_t       adel;
    } fetch_out_t;

endpackage

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with req/ack bus, hold buffer and flush handling
module if_fetch
    import cpu_defines::*;
#(
    parameter Inst_t RESET_INST = NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic [31:0] ibus_rdata_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o,
    output logic        id_adel_o
);

    fetch_state_t state_q, state_d;
    Inst_addr_t   req_addr_q, req_addr_d;
    logic         req_q, req_d;
    fetch_out_t   hold_q, hold_d;
    fetch_out_t   id_q, id_d;

    fetch_out_t   res;
    logic         res_valid;
    fetch_out_t   bubble;
    logic         aligned;
    logic         unused_stall;

    assign unused_stall = ^{stall_i[5:2], stall_i[STALL_PC]};
    assign aligned      = (pc_i[1:0] == 2'b00);

    // Next-state: FSM transitions, result production, then output/hold/bubble routing
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        hold_d     = hold_q;
        id_d       = id_q;
        res_valid  = 1'b0;
        res        = '0;

        bubble       = '0;
        bubble.pc    = id_q.pc;
        bubble.inst  = RESET_INST;

        case (state_q)
            IDLE: begin
                if (ce_i && !flush_i) begin
                    if (aligned) begin
                        req_addr_d = pc_i;
                        state_d    = BUSY;
                    end else begin
                        // Misaligned PC never reaches the bus; it becomes an AdEL marker.
                        res_valid  = 1'b1;
                        res.pc     = pc_i;
                        res.inst   = RESET_INST;
                        res.valid  = 1'b1;
                        res.adel   = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (ibus_ack_i) begin
                    state_d = IDLE;
                    if (!flush_i) begin
                        res_valid = 1'b1;
                        res.pc    = req_addr_q;
                        res.inst  = ibus_rdata_i;
                        res.valid = 1'b1;
                        res.adel  = 1'b0;
                    end
                end else if (flush_i) begin
                    // Request cannot be retracted; wait out the ack and throw it away.
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (ibus_ack_i) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (flush_i || !stall_i[STALL_IF]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            id_d   = bubble;
            hold_d = '0;
        end else if (res_valid) begin
            if (stall_i[STALL_IF]) begin
                hold_d  = res;
                state_d = HOLD;
            end else begin
                id_d = res;
            end
        end else if (!stall_i[STALL_IF]) begin
            id_d = (state_q == HOLD) ? hold_q : bubble;
        end

        req_d = (state_d == BUSY) || (state_d == DISCARD);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            req_addr_q    <= '0;
            hold_q        <= '0;
            id_q.pc       <= '0;
            id_q.inst     <= RESET_INST;
            id_q.valid    <= 1'b0;
            id_q.adel     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            req_addr_q <= req_addr_d;
            hold_q     <= hold_d;
            id_q       <= id_d;
        end
    end

    assign stallreq_o = ((state_q == IDLE) && ce_i && !flush_i && aligned)
                      || ((state_q == BUSY) && !ibus_ack_i)
                      || (state_q == DISCARD)
                      || (state_q == HOLD);

    assign ibus_req_o  = req_q;
    assign ibus_addr_o = req_addr_q;
    assign id_pc_o     = id_q.pc;
    assign id_inst_o   = id_q.inst;
    assign id_valid_o  = id_q.valid;
    assign id_adel_o   = id_q.adel;

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed and randomized self-checking bench for if_fetch
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_rdata_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        stallreq_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        id_adel_o;

    int tests = 0;
    int fails = 0;
    int sr_cnt = 0;

    // Reference model: a fetch is either outstanding (maybe killed) or a result is parked.
    logic        m_out;
    logic        m_kill;
    logic [31:0] m_addr;
    logic        m_held;
    logic [31:0] m_hpc, m_hinst;
    logic        m_hvalid, m_hadel;
    logic [31:0] e_pc, e_inst;
    logic        e_valid, e_adel;

    if_fetch #(.RESET_INST(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .ce_i        (ce_i),
        .ibus_req_o  (ibus_req_o),
        .ibus_addr_o (ibus_addr_o),
        .ibus_ack_i  (ibus_ack_i),
        .ibus_rdata_i(ibus_rdata_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .stallreq_o  (stallreq_o),
        .id_pc_o     (id_pc_o),
        .id_inst_o   (id_inst_o),
        .id_valid_o  (id_valid_o),
        .id_adel_o   (id_adel_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_stallreq();
        logic idle;
        idle = !m_out && !m_held;
        return (idle && ce_i && !flush_i && (pc_i[1:0] == 2'b00))
            || (m_out && !m_kill && !ibus_ack_i)
            || (m_out && m_kill)
            || m_held;
    endfunction

    task automatic model_edge();
        logic        prod;
        logic [31:0] p_pc, p_inst;
        logic        p_valid, p_adel;
        logic        was_held;
        prod = 1'b0; p_pc = '0; p_inst = '0; p_valid = 1'b0; p_adel = 1'b0;
        was_held = m_held;
        if (rst) begin
            m_out = 0; m_kill = 0; m_addr = '0; m_held = 0;
            m_hpc = '0; m_hinst = '0; m_hvalid = 0; m_hadel = 0;
            e_pc = '0; e_inst = '0; e_valid = 0; e_adel = 0;
            return;
        end
        if (!m_out && !m_held) begin
            if (ce_i && !flush_i) begin
                if (pc_i[1:0] == 2'b00) begin
                    m_out = 1; m_kill = 0; m_addr = pc_i;
                end else begin
                    prod = 1; p_pc = pc_i; p_inst = '0; p_valid = 1; p_adel = 1;
                end
            end
        end else if (m_out) begin
            if (ibus_ack_i) begin
                if (!m_kill && !flush_i) begin
                    prod = 1; p_pc = m_addr; p_inst = ibus_rdata_i; p_valid = 1; p_adel = 0;
                end
                m_out = 0; m_kill = 0;
            end else if (flush_i) begin
                m_kill = 1;
            end
        end
        if (flush_i) begin
            e_inst = '0; e_valid = 0; e_adel = 0;
            m_held = 0; m_hpc = '0; m_hinst = '0; m_hvalid = 0; m_hadel = 0;
        end else if (prod) begin
            if (stall_i[1]) begin
                m_held = 1; m_hpc = p_pc; m_hinst = p_inst; m_hvalid = p_valid; m_hadel = p_adel;
            end else begin
                e_pc = p_pc; e_inst = p_inst; e_valid = p_valid; e_adel = p_adel;
            end
        end else if (!stall_i[1]) begin
            if (was_held) begin
                e_pc = m_hpc; e_inst = m_hinst; e_valid = m_hvalid; e_adel = m_hadel;
                m_held = 0;
            end else begin
                e_inst = '0; e_valid = 0; e_adel = 0;
            end
        end
    endtask

    task automatic check_outputs();
        check("ibus_req",  {31'b0, ibus_req_o}, {31'b0, m_out});
        check("ibus_addr", ibus_addr_o, m_addr);
        check("id_pc",     id_pc_o, e_pc);
        check("id_inst",   id_inst_o, e_inst);
        check("id_valid",  {31'b0, id_valid_o}, {31'b0, e_valid});
        check("id_adel",   {31'b0, id_adel_o}, {31'b0, e_adel});
    endtask

    task automatic step();
        #1;
        check("stallreq", {31'b0, stallreq_o}, {31'b0, exp_stallreq()});
        if (stallreq_o) sr_cnt++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        rst = 1; pc_i = '0; ce_i = 0; ibus_ack_i = 0; ibus_rdata_i = '0; stall_i = '0; flush_i = 0;
        m_held = 0; m_out = 0; m_kill = 0;

        // Reset values
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        check("rst_req",   {31'b0, ibus_req_o}, 32'd0);
        check("rst_addr",  ibus_addr_o, 32'd0);
        check("rst_pc",    id_pc_o, 32'd0);
        check("rst_inst",  id_inst_o, 32'd0);
        check("rst_valid", {31'b0, id_valid_o}, 32'd0);
        check("rst_adel",  {31'b0, id_adel_o}, 32'd0);
        rst = 0;

        // Zero-wait fetch
        sr_cnt = 0;
        pc_i = 32'hBFC0_0000; ce_i = 1;
        step();
        check("zw_req", {31'b0, ibus_req_o}, 32'd1);
        ibus_ack_i = 1; ibus_rdata_i = 32'h2408_0001;
        step();
        ibus_ack_i = 0; ce_i = 0;
        check("zw_pc",    id_pc_o, 32'hBFC0_0000);
        check("zw_inst",  id_inst_o, 32'h2408_0001);
        check("zw_valid", {31'b0, id_valid_o}, 32'd1);
        check("zw_sr_cycles", sr_cnt, 32'd1);

        // Three wait states
        sr_cnt = 0;
        pc_i = 32'h0000_0100; ce_i = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("ws_addr", ibus_addr_o, 32'h0000_0100);
        end
        ibus_ack_i = 1; ibus_rdata_i = 32'h1234_5678;
        step();
        ibus_ack_i = 0; ce_i = 0;
        check("ws_sr_cycles", sr_cnt, 32'd4);
        check("ws_inst", id_inst_o, 32'h1234_5678);
        step();
        check("ws_bubble", {31'b0, id_valid_o}, 32'd0);

        // Stall hold
        pc_i = 32'h0000_0400; ce_i = 1;
        step();
        stall_i = 6'b000010; ibus_ack_i = 1; ibus_rdata_i = 32'h1111_2222;
        step();
        check("hold_keep_inst", id_inst_o, 32'h0);
        ibus_ack_i = 0; ce_i = 0;
        step();
        check("hold_keep_valid", {31'b0, id_valid_o}, 32'd0);
        stall_i = 6'b000000;
        step();
        check("hold_release_inst", id_inst_o, 32'h1111_2222);
        check("hold_release_pc", id_pc_o, 32'h0000_0400);
        step();
        check("hold_then_bubble", {31'b0, id_valid_o}, 32'd0);

        // Flush with a request in flight
        pc_i = 32'h0000_0200; ce_i = 1;
        step();
        ce_i = 0; flush_i = 1;
        step();
        flush_i = 0;
        step();
        ibus_ack_i = 1; ibus_rdata_i = 32'hDEAD_BEEF;
        step();
        ibus_ack_i = 0;
        check("flush_drop_valid", {31'b0, id_valid_o}, 32'd0);
        pc_i = 32'h8000_0180; ce_i = 1;
        step();
        check("flush_new_addr", ibus_addr_o, 32'h8000_0180);
        ibus_ack_i = 1; ibus_rdata_i = 32'hCAFE_0001;
        step();
        ibus_ack_i = 0; ce_i = 0;
        check("flush_new_inst", id_inst_o, 32'hCAFE_0001);

        // Misaligned PC
        pc_i = 32'h0000_0002; ce_i = 1;
        step();
        ce_i = 0;
        check("mis_req",   {31'b0, ibus_req_o}, 32'd0);
        check("mis_valid", {31'b0, id_valid_o}, 32'd1);
        check("mis_adel",  {31'b0, id_adel_o}, 32'd1);
        check("mis_inst",  id_inst_o, 32'd0);
        check("mis_pc",    id_pc_o, 32'h0000_0002);

        // Reset mid-fetch
        pc_i = 32'h0000_0300; ce_i = 1;
        step();
        rst = 1; ce_i = 0;
        step();
        rst = 0;
        check("rstmid_req",   {31'b0, ibus_req_o}, 32'd0);
        check("rstmid_pc",    id_pc_o, 32'd0);
        check("rstmid_valid", {31'b0, id_valid_o}, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(99) == 0);
            ce_i         = ($urandom_range(3) != 0);
            pc_i         = $urandom();
            if ($urandom_range(7) != 0) pc_i[1:0] = 2'b00;
            stall_i      = 6'($urandom());
            stall_i[1]   = ($urandom_range(9) < 3);
            flush_i      = ($urandom_range(9) == 0);
            ibus_ack_i   = m_out && ($urandom_range(2) == 0);
            ibus_rdata_i = $urandom();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage between the PC register and the IF/ID boundary.
- Consumes pc/ce from the PC register.
- Issues one request at a time on the instruction bus, which uses a req/ack handshake.
- Raises a stall request toward the stall controller while a fetch is outstanding.
- Presents the registered {pc, inst, valid, adel} bundle to the decode stage.
- Honours pipeline stall and exception flush, including a flush that lands while a bus transaction is in flight.

Parameters:
RESET_INST, 32'h0000_0000, instruction word driven for bubbles and reset (NOP).

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-high
pc_i  in  32  fetch address from the PC register
ce_i  in  1  fetch enable from the PC register; 0 = no fetch
ibus_req_o  out  1  instruction bus request
ibus_addr_o  out  32  instruction bus address
ibus_ack_i  in  1  bus acknowledge; rdata valid this cycle
ibus_rdata_i  in  32  bus read data
stall_i  in  6  pipeline stall vector (Stall_t); bit1 = hold IF/ID output
flush_i  in  1  exception flush
stallreq_o  out  1  stall request to the stall controller
id_pc_o  out  32  PC of the presented instruction
id_inst_o  out  32  presented instruction
id_valid_o  out  1  presented instruction is real (not a bubble)
id_adel_o  out  1  presented PC is misaligned (address-error-on-load exception)

Behaviour:
- Reset values: state IDLE; ibus_req_o=0; ibus_addr_o=0; id_pc_o=0; id_inst_o=RESET_INST; id_valid_o=0; id_adel_o=0. Hold buffer cleared.
- States: IDLE, BUSY, HOLD, DISCARD.
- ibus_req_o=1 exactly in BUSY and DISCARD. ibus_addr_o = latched req_addr. Once raised, req is never retracted before ack.
- IDLE:
  - ce_i=1, flush_i=0, pc_i[1:0]=0: latch req_addr<=pc_i, go BUSY.
  - ce_i=1, flush_i=0, pc_i[1:0]!=0: no bus request; produce {pc_i, RESET_INST, valid=1, adel=1} through the output rule; stay IDLE.
- BUSY:
  - ack with flush_i=0: produce {req_addr, rdata, valid=1, adel=0}, go IDLE.
  - ack with flush_i=1: drop the data, go IDLE.
  - no ack with flush_i=1: go DISCARD.
- DISCARD: on ack drop the data, go IDLE. Intervening flushes are ignored.
- Output rule, when a result is produced:
  - stall_i[1]=0: result loads into the id_* registers.
  - stall_i[1]=1: result goes to the hold buffer, go HOLD. id_* unchanged.
- Bubble rule: when stall_i[1]=0 and no result is produced this cycle, id_* load the bubble {id_pc_o unchanged, RESET_INST, 0, 0}.
- HOLD: when stall_i[1]=0, load the buffer into id_*, go IDLE.
- stallreq_o (combinational) = (IDLE & ce_i & ~flush_i & pc_i aligned) | (BUSY & ~ibus_ack_i) | DISCARD | HOLD.
  - Effect: the PC is held until its fetch is acknowledged. It advances in the ack cycle.
- Throughput: at most 1 instruction per 2 cycles (IDLE→BUSY→ack). Fetch latency = 1 + wait states.
- Flush outranks stall: flush_i=1 in any state forces id_* to bubble that cycle and clears the hold buffer. HOLD goes to IDLE.
- Flush also outranks ack: ack and flush in the same cycle → data discarded, nothing presented.
- rst in any state (including BUSY with an outstanding request): immediate return to reset values. The bus tolerates req deassertion on reset only.

Decomposition:
- Shared package cpu_defines holds: Inst_addr_t, Inst_t (32b), Bit_t, Stall_t (6b, bit0=PC, bit1=IF), ENABLE/DISABLE, NOP_INST, and the fetch_state_t enum {IDLE, BUSY, HOLD, DISCARD}.
- No sub-module: a single FSM plus a 66-bit hold buffer.

Test Plan:
- Zero-wait fetch: reset, pc=0xBFC00000, ce=1, ack on the first req cycle with rdata=0x24080001 → id_pc_o=0xBFC00000, id_inst_o=0x24080001, id_valid_o=1 two edges after ce. stallreq_o high for exactly 1 cycle.
- Wait states: ack 3 cycles after req → stallreq_o high for 4 cycles. ibus_addr_o stable throughout. id_valid_o pulses once.
- Stall hold: stall_i[1]=1 during the ack cycle → HOLD. id_* keep the previous value. stall_i[1] drops → id_inst_o = held word, then a bubble on the next cycle.
- Flush in flight: flush_i in the cycle after req, ack 2 cycles later with 0xDEADBEEF → data never appears. Next fetch uses the new PC 0x80000180.
- Misaligned: pc=0x00000002 → no ibus_req_o. id_valid_o=1, id_adel_o=1, id_inst_o=0.
- Reset mid-fetch: rst asserted in BUSY → next edge ibus_req_o=0 and all outputs at reset values.
